// File: rtl/p09_sound_gen.sv
// p09_sound_gen
//   Square-wave sound effect generator for a breakout-style game. Game events
//   start a tone whose pitch is a half-period counted in clk cycles and whose
//   length is counted in video frames (rising edges of vblank). A win plays a
//   three-note arpeggio; a lose plays a downward-pitch sweep.
//
// Ports
//   clk        in   system clock
//   nRst       in   asynchronous active-low reset
//   en         in   enable; low aborts playback and blocks new events
//   vblank     in   vertical blanking level; its rising edge is the frame tick
//   evt_wall   in   one-cycle event pulse, effect code 1
//   evt_paddle in   one-cycle event pulse, effect code 2
//   evt_brick  in   one-cycle event pulse, effect code 3
//   evt_win    in   one-cycle event pulse, effect code 4
//   evt_lose   in   one-cycle event pulse, effect code 5
//   sound_out  out  square-wave audio
//   busy       out  high while an effect plays
//   effect     out  current effect code (0 when idle)
module p09_sound_gen #(
    parameter int unsigned HP_WALL         = 56818,
    parameter int unsigned HP_PADDLE       = 28409,
    parameter int unsigned HP_BRICK        = 14205,
    parameter int unsigned HP_WIN0         = 23900,
    parameter int unsigned HP_WIN1         = 18968,
    parameter int unsigned HP_WIN2         = 15944,
    parameter int unsigned DUR_WALL        = 2,
    parameter int unsigned DUR_PADDLE      = 4,
    parameter int unsigned DUR_BRICK       = 3,
    parameter int unsigned WIN_NOTE_FRAMES = 8,
    parameter int unsigned HP_LOSE         = 28409,
    parameter int unsigned DUR_LOSE        = 30,
    parameter int unsigned SWEEP_STEP      = 1024
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       en,
    input  logic       vblank,
    input  logic       evt_wall,
    input  logic       evt_paddle,
    input  logic       evt_brick,
    input  logic       evt_win,
    input  logic       evt_lose,
    output logic       sound_out,
    output logic       busy,
    output logic [2:0] effect
);

    typedef enum logic {
        S_IDLE,
        S_PLAY
    } state_t;

    typedef enum logic [2:0] {
        EFF_NONE   = 3'd0,
        EFF_WALL   = 3'd1,
        EFF_PADDLE = 3'd2,
        EFF_BRICK  = 3'd3,
        EFF_WIN    = 3'd4,
        EFF_LOSE   = 3'd5
    } effect_t;

    state_t      state_q;
    effect_t     effect_q;
    logic        sound_q;
    logic        busy_q;
    logic [15:0] phase_q;
    logic [15:0] hp_q;
    logic [7:0]  frames_q;
    logic [1:0]  note_q;
    logic        vblank_q;

    effect_t     evt_code_d;
    logic [15:0] evt_hp_d;
    logic [7:0]  evt_frames_d;
    logic        accept_d;
    logic        tick_d;
    logic [15:0] next_win_hp_d;
    logic [16:0] sweep_sum_d;
    logic [15:0] sweep_hp_d;

    // Highest pulsed event code wins; its tone parameters come with it.
    always_comb begin
        evt_code_d   = EFF_NONE;
        evt_hp_d     = '0;
        evt_frames_d = '0;
        if (evt_lose) begin
            evt_code_d   = EFF_LOSE;
            evt_hp_d     = 16'(HP_LOSE);
            evt_frames_d = 8'(DUR_LOSE);
        end else if (evt_win) begin
            evt_code_d   = EFF_WIN;
            evt_hp_d     = 16'(HP_WIN0);
            evt_frames_d = 8'(WIN_NOTE_FRAMES);
        end else if (evt_brick) begin
            evt_code_d   = EFF_BRICK;
            evt_hp_d     = 16'(HP_BRICK);
            evt_frames_d = 8'(DUR_BRICK);
        end else if (evt_paddle) begin
            evt_code_d   = EFF_PADDLE;
            evt_hp_d     = 16'(HP_PADDLE);
            evt_frames_d = 8'(DUR_PADDLE);
        end else if (evt_wall) begin
            evt_code_d   = EFF_WALL;
            evt_hp_d     = 16'(HP_WALL);
            evt_frames_d = 8'(DUR_WALL);
        end
    end

    // Equal code restarts the running effect; lower codes are dropped.
    always_comb begin
        accept_d = 1'b0;
        if (en && (evt_code_d != EFF_NONE)) begin
            accept_d = (state_q == S_IDLE) || (evt_code_d >= effect_q);
        end
    end

    assign tick_d = vblank & ~vblank_q;

    always_comb begin
        next_win_hp_d = 16'(HP_WIN2);
        if (note_q == 2'd0) begin
            next_win_hp_d = 16'(HP_WIN1);
        end
    end

    // Lose sweep lowers pitch by lengthening the half-period, clamped at 16 bits.
    assign sweep_sum_d = {1'b0, hp_q} + 17'(SWEEP_STEP);
    assign sweep_hp_d  = sweep_sum_d[16] ? 16'hFFFF : sweep_sum_d[15:0];

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q  <= S_IDLE;
            effect_q <= EFF_NONE;
            sound_q  <= 1'b0;
            busy_q   <= 1'b0;
            phase_q  <= '0;
            hp_q     <= '0;
            frames_q <= '0;
            note_q   <= '0;
            vblank_q <= 1'b0;
        end else begin
            vblank_q <= vblank;
            if (!en) begin
                state_q  <= S_IDLE;
                effect_q <= EFF_NONE;
                sound_q  <= 1'b0;
                busy_q   <= 1'b0;
                phase_q  <= '0;
                note_q   <= '0;
            end else if (accept_d) begin
                // A frame tick in this same cycle is deliberately ignored.
                state_q  <= S_PLAY;
                effect_q <= evt_code_d;
                sound_q  <= 1'b0;
                busy_q   <= 1'b1;
                phase_q  <= '0;
                hp_q     <= evt_hp_d;
                frames_q <= evt_frames_d;
                note_q   <= '0;
            end else if (state_q == S_PLAY) begin
                if (phase_q == hp_q - 16'd1) begin
                    phase_q <= '0;
                    sound_q <= ~sound_q;
                end else begin
                    phase_q <= phase_q + 16'd1;
                end
                if (tick_d) begin
                    if (frames_q == 8'd1) begin
                        if ((effect_q == EFF_WIN) && (note_q < 2'd2)) begin
                            // Next arpeggio note restarts the phase; these
                            // writes override the phase update above.
                            note_q   <= note_q + 2'd1;
                            frames_q <= 8'(WIN_NOTE_FRAMES);
                            hp_q     <= next_win_hp_d;
                            phase_q  <= '0;
                        end else begin
                            state_q  <= S_IDLE;
                            effect_q <= EFF_NONE;
                            sound_q  <= 1'b0;
                            busy_q   <= 1'b0;
                            phase_q  <= '0;
                            note_q   <= '0;
                        end
                    end else begin
                        frames_q <= frames_q - 8'd1;
                        if (effect_q == EFF_LOSE) begin
                            hp_q <= sweep_hp_d;
                        end
                    end
                end
            end
        end
    end

    assign sound_out = sound_q;
    assign busy      = busy_q;
    assign effect    = effect_q;

endmodule

// File: tb/tb_p09_sound_gen.sv
// tb_p09_sound_gen
//   Directed bench for p09_sound_gen using short half-periods and durations.
//   A vector table covers priority, drop/restart, tick-vs-accept precedence and
//   enable behaviour; hand sequences cover tone timing, the win arpeggio, lose
//   sweep saturation and asynchronous reset.
module tb_p09_sound_gen;

    localparam int unsigned P_HP_WALL   = 4;
    localparam int unsigned P_HP_PADDLE = 5;
    localparam int unsigned P_HP_BRICK  = 6;
    localparam int unsigned P_HP_WIN0   = 7;
    localparam int unsigned P_HP_WIN1   = 8;
    localparam int unsigned P_HP_WIN2   = 9;
    localparam int unsigned P_HP_LOSE   = 65000;

    logic       clk;
    logic       nRst;
    logic       en;
    logic       vblank;
    logic       evt_wall;
    logic       evt_paddle;
    logic       evt_brick;
    logic       evt_win;
    logic       evt_lose;
    logic       sound_out;
    logic       busy;
    logic [2:0] effect;

    int errors;
    int checks;

    p09_sound_gen #(
        .HP_WALL        (P_HP_WALL),
        .HP_PADDLE      (P_HP_PADDLE),
        .HP_BRICK       (P_HP_BRICK),
        .HP_WIN0        (P_HP_WIN0),
        .HP_WIN1        (P_HP_WIN1),
        .HP_WIN2        (P_HP_WIN2),
        .DUR_WALL       (2),
        .DUR_PADDLE     (2),
        .DUR_BRICK      (3),
        .WIN_NOTE_FRAMES(2),
        .HP_LOSE        (P_HP_LOSE),
        .DUR_LOSE       (3),
        .SWEEP_STEP     (1024)
    ) dut (
        .clk       (clk),
        .nRst      (nRst),
        .en        (en),
        .vblank    (vblank),
        .evt_wall  (evt_wall),
        .evt_paddle(evt_paddle),
        .evt_brick (evt_brick),
        .evt_win   (evt_win),
        .evt_lose  (evt_lose),
        .sound_out (sound_out),
        .busy      (busy),
        .effect    (effect)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] evt;   // {lose, win, brick, paddle, wall}
        logic       en;
        logic       vb;
        logic       busy;
        logic [2:0] eff;
        logic       snd;
    } vec_t;

    vec_t vecs[26];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_tick();
        vblank = 1'b1;
        step();
        vblank = 1'b0;
        step();
    endtask

    // Counts cycles until sound_out changes; expects exactly hp.
    task automatic measure(input string name, input int hp);
        logic s0;
        int   n;
        s0 = sound_out;
        n  = 0;
        do begin
            step();
            n++;
        end while ((sound_out == s0) && (n < 200));
        chk(name, n, hp);
    endtask

    task automatic wait_sound_high(input string name);
        int n;
        n = 0;
        while ((sound_out !== 1'b1) && (n < 200)) begin
            step();
            n++;
        end
        chk(name, int'(sound_out), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        errors     = 0;
        checks     = 0;
        nRst       = 1'b0;
        en         = 1'b1;
        vblank     = 1'b0;
        evt_wall   = 1'b0;
        evt_paddle = 1'b0;
        evt_brick  = 1'b0;
        evt_win    = 1'b0;
        evt_lose   = 1'b0;

        //              evt        en   vb   busy eff   snd
        vecs[0]  = '{5'b10001, 1'b1, 1'b0, 1'b1, 3'd5, 1'b0}; // wall+lose -> lose
        vecs[1]  = '{5'b00100, 1'b1, 1'b0, 1'b1, 3'd5, 1'b0}; // brick dropped
        vecs[2]  = '{5'b00000, 1'b1, 1'b0, 1'b1, 3'd5, 1'b0};
        vecs[3]  = '{5'b00001, 1'b1, 1'b0, 1'b1, 3'd5, 1'b0}; // wall dropped
        vecs[4]  = '{5'b10000, 1'b1, 1'b0, 1'b1, 3'd5, 1'b0}; // lose restart
        vecs[5]  = '{5'b00000, 1'b1, 1'b1, 1'b1, 3'd5, 1'b0}; // tick 3->2
        vecs[6]  = '{5'b00000, 1'b1, 1'b0, 1'b1, 3'd5, 1'b0};
        vecs[7]  = '{5'b00000, 1'b1, 1'b1, 1'b1, 3'd5, 1'b0}; // tick 2->1
        vecs[8]  = '{5'b00000, 1'b1, 1'b0, 1'b1, 3'd5, 1'b0};
        vecs[9]  = '{5'b00000, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0}; // final tick
        vecs[10] = '{5'b00010, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0}; // paddle
        vecs[11] = '{5'b00001, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0}; // wall dropped
        vecs[12] = '{5'b00010, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0}; // restart, tick ignored
        vecs[13] = '{5'b00000, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0};
        vecs[14] = '{5'b00000, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0}; // tick 2->1, still busy
        vecs[15] = '{5'b00000, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0};
        vecs[16] = '{5'b00100, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0}; // brick preempts
        vecs[17] = '{5'b00010, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0}; // paddle dropped
        vecs[18] = '{5'b01000, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0}; // win preempts
        vecs[19] = '{5'b00100, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0}; // brick dropped
        vecs[20] = '{5'b10000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0}; // en low wins over lose
        vecs[21] = '{5'b01000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0}; // ignored while en low
        vecs[22] = '{5'b00000, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0}; // no resume
        vecs[23] = '{5'b00001, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0}; // wall
        vecs[24] = '{5'b00000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
        vecs[25] = '{5'b00000, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0};

        // Reset state
        #23;
        chk("rst_sound", int'(sound_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_effect", int'(effect), 0);
        @(negedge clk);
        nRst = 1'b1;

        // First event after reset, paddle tone timing and 2-frame duration
        evt_paddle = 1'b1;
        step();
        evt_paddle = 1'b0;
        chk("pad_busy", int'(busy), 1);
        chk("pad_effect", int'(effect), 2);
        chk("pad_snd0", int'(sound_out), 0);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("pad_lo", int'(sound_out), 0);
        end
        step();
        chk("pad_rise", int'(sound_out), 1);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("pad_hi", int'(sound_out), 1);
        end
        step();
        chk("pad_fall", int'(sound_out), 0);
        vblank = 1'b1;
        step();
        vblank = 1'b0;
        chk("pad_tick1_busy", int'(busy), 1);
        step();
        vblank = 1'b1;
        step();
        vblank = 1'b0;
        chk("pad_end_busy", int'(busy), 0);
        chk("pad_end_effect", int'(effect), 0);
        chk("pad_end_sound", int'(sound_out), 0);
        step();

        // Vector table
        for (int i = 0; i < 26; i++) begin
            {evt_lose, evt_win, evt_brick, evt_paddle, evt_wall} = vecs[i].evt;
            en     = vecs[i].en;
            vblank = vecs[i].vb;
            step();
            chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].busy));
            chk($sformatf("vec%0d_effect", i), int'(effect), int'(vecs[i].eff));
            chk($sformatf("vec%0d_sound", i), int'(sound_out), int'(vecs[i].snd));
        end
        {evt_lose, evt_win, evt_brick, evt_paddle, evt_wall} = 5'b00000;
        vblank = 1'b0;
        en     = 1'b1;
        step();

        // Win arpeggio: three notes of 2 frames each
        evt_win = 1'b1;
        step();
        evt_win = 1'b0;
        chk("win_effect", int'(effect), 4);
        measure("win_note0_hp", P_HP_WIN0);
        frame_tick();
        vblank = 1'b1;
        step();
        vblank = 1'b0;
        chk("win_note1_busy", int'(busy), 1);
        chk("win_note1_effect", int'(effect), 4);
        measure("win_note1_hp", P_HP_WIN1);
        frame_tick();
        vblank = 1'b1;
        step();
        vblank = 1'b0;
        chk("win_note2_busy", int'(busy), 1);
        measure("win_note2_hp", P_HP_WIN2);
        frame_tick();
        vblank = 1'b1;
        step();
        vblank = 1'b0;
        chk("win_end_busy", int'(busy), 0);
        chk("win_end_sound", int'(sound_out), 0);
        step();

        // Lose sweep saturates at 65535 and does not wrap
        evt_lose = 1'b1;
        step();
        evt_lose = 1'b0;
        chk("lose_effect", int'(effect), 5);
        chk("lose_hp_start", int'(dut.hp_q), 65000);
        vblank = 1'b1;
        step();
        vblank = 1'b0;
        chk("lose_hp_sat1", int'(dut.hp_q), 65535);
        step();
        vblank = 1'b1;
        step();
        vblank = 1'b0;
        chk("lose_hp_sat2", int'(dut.hp_q), 65535);
        chk("lose_busy2", int'(busy), 1);
        step();
        vblank = 1'b1;
        step();
        vblank = 1'b0;
        chk("lose_end_busy", int'(busy), 0);
        step();

        // en low mid-effect
        evt_brick = 1'b1;
        step();
        evt_brick = 1'b0;
        wait_sound_high("en_brick_high");
        en = 1'b0;
        step();
        chk("en_off_busy", int'(busy), 0);
        chk("en_off_sound", int'(sound_out), 0);
        chk("en_off_effect", int'(effect), 0);
        evt_lose = 1'b1;
        step();
        evt_lose = 1'b0;
        chk("en_off_evt_busy", int'(busy), 0);
        en = 1'b1;
        step();
        chk("en_back_busy", int'(busy), 0);

        // Asynchronous reset mid-brick with sound high
        evt_brick = 1'b1;
        step();
        evt_brick = 1'b0;
        wait_sound_high("rst_brick_high");
        #2;
        nRst = 1'b0;
        #1;
        chk("async_rst_sound", int'(sound_out), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_effect", int'(effect), 0);
        @(negedge clk);
        nRst = 1'b1;
        evt_wall = 1'b1;
        step();
        evt_wall = 1'b0;
        chk("post_rst_effect", int'(effect), 1);
        chk("post_rst_busy", int'(busy), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/p09_sound_gen.md
P09_SOUND_GEN -- requirements
Module: p09_sound_gen

Interface
REQ-001 Parameter HP_WALL, default 56818: half-period in clk cycles for the wall tone (220 Hz at 25 MHz).
REQ-002 Parameter HP_PADDLE, default 28409: paddle tone half-period (440 Hz).
REQ-003 Parameter HP_BRICK, default 14205: brick tone half-period (880 Hz).
REQ-004 Parameters HP_WIN0/1/2, defaults 23900/18968/15944: win arpeggio half-periods (C5/E5/G5).
REQ-005 Parameters DUR_WALL/DUR_PADDLE/DUR_BRICK, defaults 2/4/3: effect length in frames.
REQ-006 Parameter WIN_NOTE_FRAMES, default 8: frames per win note.
REQ-007 Parameters HP_LOSE, DUR_LOSE, SWEEP_STEP, defaults 28409/30/1024: lose sweep start half-period, length, per-frame increment.
REQ-008 clk  input  1  system clock; the only clock.
REQ-009 nRst  input  1  asynchronous active-low reset.
REQ-010 en  input  1  design enable; low aborts playback and blocks new events.
REQ-011 vblank  input  1  level from the VGA timing stage; its rising edge is the frame tick.
REQ-012 evt_wall, evt_paddle, evt_brick, evt_win, evt_lose  input  1 each  one-cycle event pulses from game logic.
REQ-013 sound_out  output  1  square-wave audio, driven to uio_out[3].
REQ-014 busy  output  1  high while an effect plays.
REQ-015 effect  output  3  current effect code: 0 none, 1 wall, 2 paddle, 3 brick, 4 win, 5 lose.

Function
REQ-016 The block SHALL implement states IDLE and PLAY; busy = (state==PLAY); effect = 0 in IDLE.
REQ-017 Event priority SHALL be lose > win > brick > paddle > wall, i.e. by effect code; with simultaneous pulses, the highest code is taken.
REQ-018 An event SHALL be accepted in IDLE, or in PLAY when its code >= current effect code (equal code restarts the effect); lower-code events SHALL be dropped.
REQ-019 On acceptance at edge N: state=PLAY, effect=code, phase counter=0, sound_out=0, frames_left=duration (WIN_NOTE_FRAMES for win, note index 0), hp=effect's half-period.
REQ-020 In PLAY the 16-bit phase counter SHALL increment each cycle; when it equals hp-1 it SHALL wrap to 0 and sound_out SHALL toggle, so the first toggle occurs hp cycles after acceptance.
REQ-021 A frame tick SHALL be vblank high with its registered previous value low (one-cycle internal edge detect).
REQ-022 Each frame tick in PLAY SHALL decrement frames_left; when decrementing from 1: for win with note index <2, advance the note, reload WIN_NOTE_FRAMES, set hp=HP_WINn and clear the phase counter; otherwise go IDLE with sound_out=0.
REQ-023 For lose, each non-final frame tick SHALL add SWEEP_STEP to hp, saturating at 65535.
REQ-024 Acceptance and a frame tick in the same cycle: acceptance SHALL take precedence (tick ignored).
REQ-025 en low SHALL force IDLE, sound_out=0 and ignore events on the same edge; playback resumes only on a new event after en returns high.
REQ-026 sound_out SHALL be 0 whenever state is IDLE; all outputs SHALL be registered.

Reset
REQ-027 While nRst is low: state=IDLE, sound_out=0, busy=0, effect=0, phase counter=0, hp=0, frames_left=0, note index=0, vblank history=0.
REQ-028 Reset assertion mid-effect SHALL silence the output immediately, without waiting for clk.
REQ-029 After nRst deasserts, the first event SHALL be accepted on the first clk edge where it is sampled high.

Verification (sim with HP_*=4..10, durations 2-3, frames every 100 cycles)
REQ-030 evt_paddle pulse, HP_PADDLE=5, DUR=2 -> busy=1, effect=2, sound_out toggles every 5 cycles, IDLE with sound_out=0 on 2nd vblank rising edge.
REQ-031 evt_wall and evt_lose in the same cycle -> effect=5; an evt_brick during lose is dropped (effect stays 5).
REQ-032 evt_win -> three notes of WIN_NOTE_FRAMES frames, toggle spacing HP_WIN0, then HP_WIN1, then HP_WIN2, then IDLE.
REQ-033 Lose with HP_LOSE=65000, SWEEP_STEP=1024 -> hp saturates at 65535 on the first tick; no wrap.
REQ-034 en driven low mid-effect -> next edge IDLE, sound_out=0; events while en=0 ignored.
REQ-035 nRst asserted mid-brick tone with sound_out=1 -> sound_out=0, busy=0, effect=0 asynchronously.
